mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. Sequences one instruction through fetch, decode, execute, memory and writeback over 3–5 states. Drives all datapath enables and muxes, and issues the 2-bit `ALUOp` consumed by the ALU control decoder. Stalls on a single memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/mc_output_decode.sv | 117 +++++++++++
 rtl/mips_multicycle_ctrl.sv | 115 +++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared states, opcodes and control encodings for the multi-cycle controller (honours MC_IMM_OPS_EN)
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] ALUB_REGB     = 2'b00;
  localparam logic [1:0] ALUB_FOUR     = 2'b01;
  localparam logic [1:0] ALUB_IMM      = 2'b10;
  localparam logic [1:0] ALUB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Single source of truth for which opcodes leave DECODE on a real path.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MC_IMM_OPS_EN
      OP_ADDI, OP_ANDI:                     return 1'b1;
`else
      OP_ADDI, OP_ANDI:                     return 1'b0;
`endif
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - combinational map from controller state to datapath controls (honours MC_IMM_OPS_EN)
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       is_andi,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

`ifndef MC_IMM_OPS_EN
  logic unused_is_andi;
  assign unused_is_andi = is_andi;
`endif

  // Per-state control decode; anything not named for a state stays 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REGB;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SHL2;
        if (!op_supported(opcode)) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
`ifdef MC_IMM_OPS_EN
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_op    = is_andi ? ALUOP_AND : ALUOP_ADD;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS main control FSM (immediate ops enabled by MC_IMM_OPS_EN)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int IMEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  // Reserved parameter: there is no fetch timeout, stalls last as long as mem_ready is low.
  localparam int unused_imem_wait_max = IMEM_WAIT_MAX;

  // The branch condition is applied by the datapath, not by this FSM.
  logic unused_zero;
  assign unused_zero = zero;

  state_t state_q;
  state_t state_d;
  logic   is_andi;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef MC_IMM_OPS_EN
  // Capture addi/andi selection in DECODE so I_EXEC does not depend on opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     is_andi <= 1'b0;
    else if (state_q == S_DECODE)   is_andi <= (opcode == OP_ANDI);
  end
`else
  assign is_andi = 1'b0;
`endif

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
`ifdef MC_IMM_OPS_EN
        if (opcode == OP_ADDI || opcode == OP_ANDI) state_d = S_I_EXEC;
`endif
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
`ifdef MC_IMM_OPS_EN
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

  mc_output_decode u_decode (
    .state         (state_q),
    .is_andi       (is_andi),
    .mem_ready     (mem_ready),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl (expectations follow MC_IMM_OPS_EN)
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic       instr_done, illegal_op;
  logic [3:0] state;
  logic [17:0] dut_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.IMEM_WAIT_MAX(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
                    alu_op, instr_done, illegal_op};

  // Ordered list of states an instruction walks through, from its opcode.
  function automatic void build_path(input logic [5:0] op, output int p[5], output int n);
    p = '{0, 1, 0, 0, 0};
    n = 2;
    case (op)
      6'b000000: begin p = '{0, 1, 6, 7, 0};  n = 4; end
      6'b100011: begin p = '{0, 1, 2, 3, 4};  n = 5; end
      6'b101011: begin p = '{0, 1, 2, 5, 0};  n = 4; end
      6'b000100: begin p = '{0, 1, 8, 0, 0};  n = 3; end
      6'b000010: begin p = '{0, 1, 9, 0, 0};  n = 3; end
`ifdef MC_IMM_OPS_EN
      6'b001000, 6'b001100: begin p = '{0, 1, 10, 11, 0}; n = 4; end
`endif
      default: begin p = '{0, 1, 0, 0, 0}; n = 2; end
    endcase
  endfunction

  // Control table per state, packed like dut_vec.
  function automatic logic [17:0] exp_vec(input int st, input logic andi, input logic mr,
                                          input logic done, input logic ill);
    logic pcw, pcwc, iod, mrd, mwr, irw, m2r, rw, rd, asa;
    logic [1:0] asb, pcs, aop;
    {pcw, pcwc, iod, mrd, mwr, irw, m2r, rw, rd, asa} = 10'd0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; end
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mrd = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; iod = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; aop = andi ? 2'b11 : 2'b00; end
      11: begin rw = 1'b1; end
      default: begin end
    endcase
    return {pcw, pcwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, asb, pcs, aop, done, ill};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b111111;
    #2;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (dut_vec !== exp_vec(0, 1'b0, 1'b1, 1'b0, 1'b0))
      begin errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, exp_vec(0, 1'b0, 1'b1, 1'b0, 1'b0)); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    int exp_s[4] = '{0, 1, 6, 7};
    int dones = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; opcode = 6'b000000; #1;
      checks++;
      if (state !== 4'(exp_s[i])) begin errors++; $display("FAIL rtype_state i=%0d got=%0d exp=%0d", i, state, exp_s[i]); end
      if (i == 2) begin
        checks++;
        if (alu_op !== 2'b10) begin errors++; $display("FAIL rtype_aluop got=%b exp=10", alu_op); end
      end
      if (i == 3) begin
        checks++;
        if ({reg_write, reg_dst} !== 2'b11) begin errors++; $display("FAIL rtype_wb got=%b exp=11", {reg_write, reg_dst}); end
      end
      if (instr_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL rtype_done_count got=%0d exp=1", dones); end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL rtype_end got=%0d exp=0", state); end
  endtask

  task automatic test_lw_stall();
    int   exp_s[7] = '{0, 1, 2, 3, 3, 3, 4};
    logic mr_s[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr_s[i]; opcode = (i == 0) ? 6'b010101 : 6'b100011; #1;
      checks++;
      if (state !== 4'(exp_s[i])) begin errors++; $display("FAIL lw_state i=%0d got=%0d exp=%0d", i, state, exp_s[i]); end
      if (exp_s[i] == 3) begin
        checks++;
        if (dut_vec !== exp_vec(3, 1'b0, mr_s[i], 1'b0, 1'b0))
          begin errors++; $display("FAIL lw_stall_outputs i=%0d got=%h", i, dut_vec); end
      end
      if (i == 6) begin
        checks++;
        if ({reg_write, mem_to_reg, instr_done} !== 3'b111)
          begin errors++; $display("FAIL lw_wb got=%b exp=111", {reg_write, mem_to_reg, instr_done}); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL lw_end got=%0d exp=0", state); end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops[2]  = '{6'b000100, 6'b000010};
    int         last[2] = '{8, 9};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; opcode = ops[k]; #1;
        checks++;
        if (state !== 4'((i == 2) ? last[k] : i))
          begin errors++; $display("FAIL bj_state k=%0d i=%0d got=%0d", k, i, state); end
        if (i == 2 && k == 0) begin
          checks++;
          if ({alu_op, pc_write_cond, pc_source, instr_done} !== 6'b01_1_01_1)
            begin errors++; $display("FAIL beq_ctrl got=%b exp=011011", {alu_op, pc_write_cond, pc_source, instr_done}); end
        end
        if (i == 2 && k == 1) begin
          checks++;
          if ({pc_source, pc_write, instr_done} !== 4'b10_1_1)
            begin errors++; $display("FAIL j_ctrl got=%b exp=1011", {pc_source, pc_write, instr_done}); end
        end
        @(posedge clk); #1;
      end
    end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL bj_end got=%0d exp=0", state); end
  endtask

  task automatic test_imm();
    mem_ready = 1'b1; opcode = 6'b001100; #1;
    @(posedge clk); #1;
    opcode = 6'b001100; #1;
`ifdef MC_IMM_OPS_EN
    checks++;
    if (illegal_op !== 1'b0) begin errors++; $display("FAIL andi_legal got=%b exp=0", illegal_op); end
    @(posedge clk); #1;
    opcode = 6'b000000; #1;
    checks++;
    if ({state, alu_op} !== {4'd10, 2'b11}) begin errors++; $display("FAIL andi_exec got=%0d/%b exp=10/11", state, alu_op); end
    @(posedge clk); #1;
    checks++;
    if ({state, reg_write, instr_done} !== {4'd11, 2'b11}) begin errors++; $display("FAIL andi_wb got=%0d", state); end
    @(posedge clk); #1;
`else
    checks++;
    if ({illegal_op, instr_done} !== 2'b11) begin errors++; $display("FAIL andi_illegal got=%b exp=11", {illegal_op, instr_done}); end
    @(posedge clk); #1;
`endif
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL imm_end got=%0d exp=0", state); end
  endtask

  task automatic test_illegal();
    mem_ready = 1'b1; opcode = 6'b000000; #1;
    @(posedge clk); #1;
    opcode = 6'b111111; #1;
    checks++;
    if ({state, illegal_op, instr_done} !== {4'd1, 2'b11})
      begin errors++; $display("FAIL illegal_decode got=%0d/%b exp=1/11", state, {illegal_op, instr_done}); end
    @(posedge clk); #1;
    checks++;
    if ({state, illegal_op} !== {4'd0, 1'b0}) begin errors++; $display("FAIL illegal_end got=%0d exp=0", state); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b1; opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    mem_ready = 1'b0; #1;
    checks++;
    if (state !== 4'd3) begin errors++; $display("FAIL rstmid_pre got=%0d exp=3", state); end
    #1;
    rst_n = 1'b0; #1;
    checks++;
    if ({state, instr_done} !== {4'd0, 1'b0}) begin errors++; $display("FAIL rstmid_async got=%0d/%b exp=0/0", state, instr_done); end
    @(posedge clk); #1;
    mem_ready = 1'b1; #1;
    checks++;
    if ({state, instr_done} !== {4'd0, 1'b0}) begin errors++; $display("FAIL rstmid_hold got=%0d exp=0", state); end
    rst_n = 1'b1; #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL rstmid_release got=%0d exp=0", state); end
    @(posedge clk); #1;
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL rstmid_after got=%0d exp=1", state); end
    opcode = 6'b111111;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int n_instr);
    int p[5];
    int n, idx, guard, st;
    logic [5:0] op;
    logic mr, memstate, done, ill;
    logic [17:0] ev;
    for (int k = 0; k < n_instr; k++) begin
      case ($urandom_range(0, 9))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        6: op = 6'b001100;
        default: op = 6'($urandom);
      endcase
      build_path(op, p, n);
      idx = 0;
      guard = 0;
      while (idx < n && guard < 64) begin
        st = p[idx];
        mr = ($urandom_range(0, 3) != 0);
        mem_ready = mr;
        opcode = (st == 1 || st == 2) ? op : 6'($urandom);
        memstate = (st == 0 || st == 3 || st == 5);
        done = (idx == n - 1) && (!memstate || mr);
        ill = (st == 1) && (n == 2);
        ev = exp_vec(st, (op == 6'b001100), mr, done, ill);
        #1;
        checks++;
        if (state !== 4'(st)) begin errors++; $display("FAIL rand_state k=%0d op=%b got=%0d exp=%0d", k, op, state, st); end
        checks++;
        if (dut_vec !== ev) begin errors++; $display("FAIL rand_outputs k=%0d st=%0d got=%h exp=%h", k, st, dut_vec, ev); end
        @(posedge clk); #1;
        if (!memstate || mr) idx++;
        guard++;
      end
      if (guard >= 64) begin
        checks++; errors++;
        $display("FAIL rand_timeout k=%0d got=%0d exp=<64 cycles", k, guard);
      end
    end
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL rand_end got=%0d exp=0", state); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch_jump();
    test_imm();
    test_illegal();
    test_reset_mid();
    test_random(80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
